// File: rtl/conv3x3_mac.sv
// conv3x3_mac
//   3x3 convolution MAC stage sitting behind the X window buffer. It holds a
//   9-tap signed 8-bit kernel, multiplies the current 3x3 window of unsigned
//   8-bit pixels by it and emits one ACC_W-bit result per window position
//   through a valid/ready handshake. It also steers the window buffer: ALU_en
//   asks it to shift one column, row_finish marks the last column of a row.
//
//   Optional build macro: CONV_RELU_SAT_EN
//     defined   -> the result is clamped to [0,255] and zero-extended to ACC_W
//     undefined -> the result is the raw signed ACC_W sum
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   w_valid, w_data     kernel words, accepted in IDLE only; byte0 = lowest tap
//   start               begin a frame (IDLE with a complete kernel loaded)
//   row_ready           buffer holds a valid window for the current row
//   X_reg1..X_reg3      window rows 0..2; [23:16] left pixel, [7:0] right pixel
//   ALU_en              window consumed, buffer shifts one byte
//   row_finish          1-cycle pulse when the last column of a row is consumed
//   row_count           current output row index
//   out_valid/out_ready/out_data   result handshake
//   busy                frame in progress (state != IDLE)
//   done                1-cycle pulse when the frame has fully drained
module conv3x3_mac #(
  parameter int COLS  = 28,
  parameter int ROWS  = 28,
  parameter int ACC_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_valid,
  input  logic [31:0]      w_data,
  input  logic             start,
  input  logic             row_ready,
  input  logic [23:0]      X_reg1,
  input  logic [23:0]      X_reg2,
  input  logic [23:0]      X_reg3,
  output logic             ALU_en,
  output logic             row_finish,
  output logic [4:0]       row_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int              CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
  localparam logic [4:0]      ROW_LAST = 5'(ROWS - 1);

  state_t                  state;
  logic signed [7:0]       w [9];
  logic [1:0]              w_cnt;
  logic                    k_ok;
  logic [CW-1:0]           col;
  logic signed [16:0]      prod [9];
  logic                    v1, v2;
  logic                    stall, consume, last_col;
  logic [71:0]             win;
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0]        res;

  // Tap i sits at byte i counted from the MSB: row-major, left pixel first.
  assign win      = {X_reg1, X_reg2, X_reg3};

  assign stall    = v2 && !out_ready;
  assign consume  = (state == RUN) && row_ready && !stall;
  assign last_col = (col == COL_LAST);

  assign ALU_en     = consume && !last_col;
  assign row_finish = consume && last_col;
  assign out_valid  = v2;
  assign busy       = (state != IDLE);
  assign done       = (state == DRAIN) && !v1 && !v2;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      sum = sum + ACC_W'(prod[i]);
    end
  end

`ifdef CONV_RELU_SAT_EN
  always_comb begin
    if (sum[ACC_W-1]) begin
      res = '0;
    end else if (|sum[ACC_W-2:8]) begin
      res = ACC_W'(255);
    end else begin
      res = {{(ACC_W-8){1'b0}}, sum[7:0]};
    end
  end
`else
  assign res = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w_cnt     <= '0;
      k_ok      <= 1'b0;
      col       <= '0;
      row_count <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_data  <= '0;
      for (int unsigned i = 0; i < 9; i++) begin
        w[i]    <= '0;
        prod[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (w_valid) begin
            case (w_cnt)
              2'd0: begin
                w[0] <= w_data[7:0];   w[1] <= w_data[15:8];
                w[2] <= w_data[23:16]; w[3] <= w_data[31:24];
                w_cnt <= 2'd1;
              end
              2'd1: begin
                w[4] <= w_data[7:0];   w[5] <= w_data[15:8];
                w[6] <= w_data[23:16]; w[7] <= w_data[31:24];
                w_cnt <= 2'd2;
              end
              default: begin
                w[8]  <= w_data[7:0];
                k_ok  <= 1'b1;
                w_cnt <= 2'd0;
              end
            endcase
          end
          if (start && k_ok) begin
            state     <= RUN;
            col       <= '0;
            row_count <= '0;
          end
        end
        RUN: begin
          if (consume) begin
            if (last_col) begin
              col <= '0;
              if (row_count == ROW_LAST) begin
                row_count <= '0;
                state     <= DRAIN;
              end else begin
                row_count <= row_count + 5'd1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!v1 && !v2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Both stages freeze together on backpressure so nothing is lost.
      if (!stall) begin
        v1 <= consume;
        v2 <= v1;
        if (consume) begin
          for (int unsigned i = 0; i < 9; i++) begin
            prod[i] <= $signed({1'b0, win[8*(8-i) +: 8]}) * w[i];
          end
        end
        if (v1) out_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac (small COLS/ROWS geometry).
// The bench plays the X window buffer from its own image, keeps a reference
// kernel, and queues the expected frame results before each frame starts.
module tb_conv3x3_mac;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int ACC_W = 21;

`ifdef CONV_RELU_SAT_EN
  localparam logic [ACC_W-1:0] EXP_NEG = '0;
`else
  localparam logic [ACC_W-1:0] EXP_NEG = ACC_W'(-32640);
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             w_valid;
  logic [31:0]      w_data;
  logic             start;
  logic             row_ready;
  logic [23:0]      X_reg1, X_reg2, X_reg3;
  logic             ALU_en, row_finish;
  logic [4:0]       row_count;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy, done;

  conv3x3_mac #(.COLS(COLS), .ROWS(ROWS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .start(start),
    .row_ready(row_ready), .X_reg1(X_reg1), .X_reg2(X_reg2), .X_reg3(X_reg3),
    .ALU_en(ALU_en), .row_finish(row_finish), .row_count(row_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0]        img [ROWS+2][COLS+2];
  logic signed [7:0] kw [9];
  logic [ACC_W-1:0]  exp_q [$];
  int tests = 0;
  int fails = 0;
  int brow, bcol;
  int n_alu, n_rf, n_res, n_done, first_cons, first_val;
  logic [ACC_W-1:0] first_res;

  function automatic logic [ACC_W-1:0] model(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(kw[3*i+j]) * int'(img[r+i][c+j]);
`ifdef CONV_RELU_SAT_EN
    if (s < 0) s = 0;
    if (s > 255) s = 255;
`endif
    return ACC_W'(s);
  endfunction

  task automatic fill_img(input int v);
    for (int r = 0; r < ROWS + 2; r++)
      for (int c = 0; c < COLS + 2; c++)
        img[r][c] = (v < 0) ? 8'($urandom_range(0, 255)) : 8'(v);
  endtask

  task automatic rand_kernel();
    for (int i = 0; i < 9; i++) kw[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic drive_window();
    int r = (brow < ROWS) ? brow : ROWS - 1;
    int c = (bcol < COLS) ? bcol : COLS - 1;
    X_reg1 = {img[r][c],   img[r][c+1],   img[r][c+2]};
    X_reg2 = {img[r+1][c], img[r+1][c+1], img[r+1][c+2]};
    X_reg3 = {img[r+2][c], img[r+2][c+1], img[r+2][c+2]};
  endtask

  task automatic load_words(input int first, input int last);
    logic [31:0] wd [3];
    wd[0] = {kw[3], kw[2], kw[1], kw[0]};
    wd[1] = {kw[7], kw[6], kw[5], kw[4]};
    wd[2] = {8'($urandom), 8'($urandom), 8'($urandom), kw[8]};
    for (int i = first; i <= last; i++) begin
      @(negedge clk); w_valid = 1'b1; w_data = wd[i];
    end
    @(negedge clk); w_valid = 1'b0;
  endtask

  // mode 0: always ready; 1: out_ready low 5 cycles mid-row; 2: random both.
  task automatic run_frame(input int mode, input bit garbage);
    bit               frame_done = 0;
    bit               prev_hold = 0;
    logic [ACC_W-1:0] prev_data = '0;
    logic [ACC_W-1:0] e;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_q.push_back(model(r, c));
    brow = 0; bcol = 0;
    n_alu = 0; n_rf = 0; n_res = 0; n_done = 0; first_cons = -1; first_val = -1;
    @(negedge clk); start = 1'b1; drive_window();
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 400 && !frame_done; cyc++) begin
      drive_window();
      row_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = (mode == 1) ? !(cyc >= 4 && cyc < 9)
                : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (garbage) begin w_valid = 1'b1; w_data = $urandom; end
      #1;
      if (ALU_en || row_finish) begin
        tests++;
        if ({ALU_en, row_finish} === 2'b11) begin
          fails++; $display("FAIL alu_and_finish both high at cyc %0d", cyc);
        end
        if (first_cons < 0) first_cons = cyc;
      end
      if (!row_ready) begin
        tests++;
        if ((ALU_en | row_finish) !== 1'b0) begin
          fails++; $display("FAIL consume_no_row_ready got alu=%b rf=%b exp 0", ALU_en, row_finish);
        end
      end
      if (out_valid && !out_ready) begin
        tests++;
        if ((ALU_en | row_finish) !== 1'b0) begin
          fails++; $display("FAIL consume_in_stall got alu=%b rf=%b exp 0", ALU_en, row_finish);
        end
      end
      if (prev_hold) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          fails++;
          $display("FAIL hold got v=%b d=%0d exp v=1 d=%0d", out_valid, out_data, prev_data);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (row_finish) begin
        tests++;
        if (row_count !== 5'(n_rf)) begin
          fails++; $display("FAIL row_count got %0d exp %0d", row_count, n_rf);
        end
        n_rf++;
      end
      if (ALU_en) n_alu++;
      if (out_valid && first_val < 0) first_val = cyc;
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL extra_result got %0d exp none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (n_res == 0) first_res = out_data;
          if (out_data !== e) begin
            fails++;
            $display("FAIL result[%0d] got %0d exp %0d", n_res, $signed(out_data), $signed(e));
          end
        end
        n_res++;
      end
      if (done) begin n_done++; frame_done = 1; end
      if (ALU_en) bcol++;
      if (row_finish) begin bcol = 0; brow++; end
      @(negedge clk);
    end
    w_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (n_done !== 1) begin fails++; $display("FAIL frame_done got %0d pulses exp 1", n_done); end
    tests++;
    if (exp_q.size() !== 0) begin
      fails++; $display("FAIL missing_results got %0d left exp 0", exp_q.size());
    end
    exp_q.delete();
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL after_frame got busy=%b done=%b exp 00", busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; w_valid = 1'b0; w_data = '0; start = 1'b0; row_ready = 1'b1;
    out_ready = 1'b1; X_reg1 = '1; X_reg2 = '1; X_reg3 = '1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if ({ALU_en, row_finish, out_valid, busy, done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 00000", {ALU_en, row_finish, out_valid, busy, done});
    end
    tests++;
    if (row_count !== 5'd0) begin fails++; $display("FAIL reset_row_count got %0d exp 0", row_count); end
    tests++;
    if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
    rst = 1'b0;
  endtask

  task automatic test_kernel_ones();
    for (int i = 0; i < 9; i++) kw[i] = 8'sd1;
    fill_img(1);
    load_words(0, 2);
    run_frame(0, 0);
    tests++;
    if (first_res !== ACC_W'(9)) begin fails++; $display("FAIL ones_value got %0d exp 9", first_res); end
    tests++;
    if (first_val - first_cons !== 2) begin
      fails++; $display("FAIL latency got %0d exp 2", first_val - first_cons);
    end
  endtask

  task automatic test_negative();
    for (int i = 0; i < 9; i++) kw[i] = '0;
    kw[4] = 8'h80;
    fill_img(255);
    load_words(0, 2);
    run_frame(0, 0);
    tests++;
    if (first_res !== EXP_NEG) begin
      fails++; $display("FAIL neg_value got %0d exp %0d", $signed(first_res), $signed(EXP_NEG));
    end
  endtask

  task automatic test_frame_control();
    rand_kernel(); fill_img(-1);
    load_words(0, 2);
    run_frame(0, 0);
    tests++;
    if (n_alu !== ROWS * (COLS - 1)) begin
      fails++; $display("FAIL alu_count got %0d exp %0d", n_alu, ROWS * (COLS - 1));
    end
    tests++;
    if (n_rf !== ROWS) begin fails++; $display("FAIL finish_count got %0d exp %0d", n_rf, ROWS); end
    tests++;
    if (n_res !== ROWS * COLS) begin
      fails++; $display("FAIL result_count got %0d exp %0d", n_res, ROWS * COLS);
    end
  endtask

  task automatic test_backpressure();
    rand_kernel(); fill_img(-1);
    load_words(0, 2);
    run_frame(1, 0);
    tests++;
    if (n_res !== ROWS * COLS) begin
      fails++; $display("FAIL bp_result_count got %0d exp %0d", n_res, ROWS * COLS);
    end
  endtask

  task automatic test_ignore();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    rand_kernel(); fill_img(-1);
    load_words(0, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL early_start got busy=%b exp 0", busy); end
    load_words(2, 2);
    run_frame(0, 1);
  endtask

  task automatic test_back_to_back();
    fill_img(-1);
    run_frame(2, 0);
    fill_img(-1);
    run_frame(2, 0);
  endtask

  task automatic test_reset_mid();
    rand_kernel(); fill_img(-1);
    load_words(0, 2);
    brow = 0; bcol = 0; row_ready = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b1; drive_window();
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 20 && bcol != 2; cyc++) begin
      drive_window(); #1;
      if (ALU_en) bcol++;
      @(negedge clk);
    end
    tests++;
    if (bcol !== 2) begin fails++; $display("FAIL reach_col2 got %0d exp 2", bcol); end
    rst = 1'b1;
    @(negedge clk); #1;
    tests++;
    if ({ALU_en, row_finish, out_valid, busy, done} !== 5'b0) begin
      fails++;
      $display("FAIL midrst_ctrl got %b exp 00000", {ALU_en, row_finish, out_valid, busy, done});
    end
    tests++;
    if (row_count !== 5'd0 || out_data !== '0) begin
      fails++; $display("FAIL midrst_data got rc=%0d d=%0d exp 0 0", row_count, out_data);
    end
    rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_no_kernel got busy=%b exp 0", busy); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_kernel_ones();
    test_negative();
    test_frame_control();
    test_backpressure();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
